// File: rtl/hub75_row_driver_pkg.sv
// Shared types for the HUB75 row driver: panel geometry, row bundle,
// FSM state encoding, pin bundle and the column-to-pin mapping helper.
package hub75_row_driver_pkg;

    localparam int GL_NUM_COL_PIXELS = 32;
    localparam int GL_RGB_COL_W      = 3 * GL_NUM_COL_PIXELS;
    localparam int GL_RGB_ROW_W      = 2 * GL_RGB_COL_W;
    localparam int GL_COL_IDX_W      = $clog2(GL_NUM_COL_PIXELS);

    // One half-panel row: one bit per column for each colour plane.
    typedef struct packed {
        logic [GL_NUM_COL_PIXELS-1:0] red;
        logic [GL_NUM_COL_PIXELS-1:0] green;
        logic [GL_NUM_COL_PIXELS-1:0] blue;
    } rgb_col_t;

    typedef struct packed {
        rgb_col_t top;
        rgb_col_t bot;
    } rgb_row_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
        WAIT_DISP = 3'd2,
        BLANK     = 3'd3,
        LATCH     = 3'd4
    } hub75_state_t;

    typedef struct packed {
        logic [5:0] rgb;
        logic       clk;
        logic       lat;
        logic       oe_n;
        logic [3:0] addr;
    } hub75_pins_t;

    // Pin order on the connector is {b1,g1,r1,b0,g0,r0}.
    function automatic logic [5:0] hub75_column_bits(
        input rgb_row_t                row,
        input logic [GL_COL_IDX_W-1:0] col
    );
        return {row.bot.blue[col], row.bot.green[col], row.bot.red[col],
                row.top.blue[col], row.top.green[col], row.top.red[col]};
    endfunction

endpackage

// File: rtl/hub75_column_shifter.sv
// Serialises one rgb_row_t onto the six colour pins and the shift clock,
// last column first.
// Ports: clk_in/n_reset_in clock and async active-low reset; start_in loads
//  column N-1 from row_in on this edge; row_in must stay valid while busy;
//  busy_out high while shifting; done_out high in the final cycle of the
//  last column; rgb_out/clk_out registered panel colour bits and shift clock.
module hub75_column_shifter
    import hub75_row_driver_pkg::*;
#(
    parameter int unsigned SCLK_HALF_PERIOD = 2
) (
    input  logic       clk_in,
    input  logic       n_reset_in,
    input  logic       start_in,
    input  rgb_row_t   row_in,
    output logic       busy_out,
    output logic       done_out,
    output logic [5:0] rgb_out,
    output logic       clk_out
);

    localparam int DIV_W = (SCLK_HALF_PERIOD > 1) ? $clog2(SCLK_HALF_PERIOD) : 1;
    localparam int COL_W = GL_COL_IDX_W;

    logic             busy_q, busy_d;
    logic             high_q, high_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [5:0]       rgb_q, rgb_d;
    logic             sclk_q, sclk_d;
    logic             half_end;

    assign half_end = (div_q == DIV_W'(SCLK_HALF_PERIOD - 1));

    // Combinational so the top can leave SHIFT on the same edge the
    // clock returns low, keeping the shift window exactly N*2*H cycles.
    assign done_out = busy_q & high_q & half_end & (col_q == '0);
    assign busy_out = busy_q;
    assign rgb_out  = rgb_q;
    assign clk_out  = sclk_q;

    always_comb begin
        busy_d = busy_q;
        high_d = high_q;
        div_d  = div_q;
        col_d  = col_q;
        rgb_d  = rgb_q;
        sclk_d = sclk_q;
        if (start_in) begin
            busy_d = 1'b1;
            high_d = 1'b0;
            div_d  = '0;
            col_d  = COL_W'(GL_NUM_COL_PIXELS - 1);
            rgb_d  = hub75_column_bits(row_in, COL_W'(GL_NUM_COL_PIXELS - 1));
            sclk_d = 1'b0;
        end else if (busy_q) begin
            if (half_end) begin
                div_d = '0;
                if (!high_q) begin
                    sclk_d = 1'b1;
                    high_d = 1'b1;
                end else if (col_q == '0) begin
                    sclk_d = 1'b0;
                    high_d = 1'b0;
                    busy_d = 1'b0;
                end else begin
                    col_d  = col_q - COL_W'(1);
                    rgb_d  = hub75_column_bits(row_in, col_q - COL_W'(1));
                    sclk_d = 1'b0;
                    high_d = 1'b0;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            busy_q <= 1'b0;
            high_q <= 1'b0;
            div_q  <= '0;
            col_q  <= '0;
            rgb_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            high_q <= high_d;
            div_q  <= div_d;
            col_q  <= col_d;
            rgb_q  <= rgb_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 row driver: accepts one row per valid/ready transfer, shifts it
// while the previous row stays lit, then blanks, latches and re-enables.
// Ports: clk_in/n_reset_in clock and async active-low reset; row_in,
//  row_address_in, row_valid_in, row_ready_out row handshake; row_done_out
//  one-cycle pulse after latch; panel_*_out registered connector pins.
module hub75_row_driver
    import hub75_row_driver_pkg::*;
#(
    parameter int unsigned SCLK_HALF_PERIOD = 2,
    parameter int unsigned BLANK_CYCLES     = 2,
    parameter int unsigned LATCH_CYCLES     = 2,
    parameter int unsigned DISPLAY_CYCLES   = 1000
) (
    input  logic       clk_in,
    input  logic       n_reset_in,
    input  rgb_row_t   row_in,
    input  logic [3:0] row_address_in,
    input  logic       row_valid_in,
    output logic       row_ready_out,
    output logic       row_done_out,
    output logic [5:0] panel_rgb_out,
    output logic       panel_clk_out,
    output logic       panel_lat_out,
    output logic       panel_oe_n_out,
    output logic [3:0] panel_addr_out
);

    localparam int CNT_W  = $clog2(DISPLAY_CYCLES + 1);
    localparam int PH_MAX = (BLANK_CYCLES > LATCH_CYCLES) ? BLANK_CYCLES : LATCH_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    hub75_state_t state_q, state_d;
    rgb_row_t     hold_q, hold_d;
    logic [3:0]   addr_hold_q, addr_hold_d;
    logic         ready_q, ready_d;
    logic         done_q, done_d;
    logic         lat_q, lat_d;
    logic         oe_n_q, oe_n_d;
    logic [3:0]   addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;

    logic        accept;
    logic        disp_done;
    rgb_row_t    shift_row;
    logic        sh_busy;
    logic        sh_done;
    logic [5:0]  sh_rgb;
    logic        sh_clk;
    hub75_pins_t pins;

    assign accept = row_valid_in & ready_q & ~sh_busy;

    // The counter hits zero on this edge, so the lit time is exactly
    // DISPLAY_CYCLES; a zero counter (after reset) also counts as expired.
    assign disp_done = (cnt_q <= CNT_W'(1));

    // The first column is taken straight from row_in on the accept edge.
    assign shift_row = accept ? row_in : hold_q;

    hub75_column_shifter #(
        .SCLK_HALF_PERIOD(SCLK_HALF_PERIOD)
    ) u_shifter (
        .clk_in    (clk_in),
        .n_reset_in(n_reset_in),
        .start_in  (accept),
        .row_in    (shift_row),
        .busy_out  (sh_busy),
        .done_out  (sh_done),
        .rgb_out   (sh_rgb),
        .clk_out   (sh_clk)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        addr_hold_d = addr_hold_q;
        lat_d       = lat_q;
        oe_n_d      = oe_n_q;
        addr_d      = addr_q;
        ph_d        = ph_q;
        done_d      = 1'b0;
        cnt_d       = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    hold_d      = row_in;
                    addr_hold_d = row_address_in;
                    state_d     = SHIFT;
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    if (disp_done) begin
                        state_d = BLANK;
                        oe_n_d  = 1'b1;
                        ph_d    = '0;
                    end else begin
                        state_d = WAIT_DISP;
                    end
                end
            end
            WAIT_DISP: begin
                if (disp_done) begin
                    state_d = BLANK;
                    oe_n_d  = 1'b1;
                    ph_d    = '0;
                end
            end
            BLANK: begin
                if (ph_q == PH_W'(BLANK_CYCLES - 1)) begin
                    state_d = LATCH;
                    lat_d   = 1'b1;
                    addr_d  = addr_hold_q;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            LATCH: begin
                if (ph_q == PH_W'(LATCH_CYCLES - 1)) begin
                    state_d = IDLE;
                    lat_d   = 1'b0;
                    oe_n_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = CNT_W'(DISPLAY_CYCLES);
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            addr_hold_q <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            lat_q       <= 1'b0;
            oe_n_q      <= 1'b1;
            addr_q      <= '0;
            cnt_q       <= '0;
            ph_q        <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            addr_hold_q <= addr_hold_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            lat_q       <= lat_d;
            oe_n_q      <= oe_n_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
        end
    end

    assign pins = '{rgb: sh_rgb, clk: sh_clk, lat: lat_q,
                    oe_n: oe_n_q, addr: addr_q};

    assign row_ready_out  = ready_q;
    assign row_done_out   = done_q;
    assign panel_rgb_out  = pins.rgb;
    assign panel_clk_out  = pins.clk;
    assign panel_lat_out  = pins.lat;
    assign panel_oe_n_out = pins.oe_n;
    assign panel_addr_out = pins.addr;

endmodule
